uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001: Port CLK, input, 1 -- single system clock; all state updates on rising edge.
REQ-002: Port RST, input, 1 -- reset, synchronous and active-high.
REQ-003: Port RX_IN, input, 1 -- serial line; idle high.
REQ-004: Port PAR_EN, input, 1 -- 1 = frame carries a parity bit.
REQ-005: Port Prescale, input, 6 -- oversampling ratio P; legal values 8, 16, 32.
REQ-006: Port strt_glitch, input, 1 -- registered start-check result; 1 = glitch.
REQ-007: Port par_err, input, 1 -- registered parity-check result.
REQ-008: Port stp_err, input, 1 -- registered stop-check result.
REQ-009: Port dat_samp_en, output, 1 -- enables the data-sampling stage.
REQ-010: Port strt_chk_en, output, 1 -- one-cycle strobe to the start checker.
REQ-011: Port deser_en, output, 1 -- one-cycle strobe to the deserializer.
REQ-012: Port par_chk_en, output, 1 -- one-cycle strobe to the parity checker.
REQ-013: Port stp_chk_en, output, 1 -- one-cycle strobe to the stop checker.
REQ-014: Port edge_cnt, output, 6 -- oversample edge index within the current bit.
REQ-015: Port bit_cnt, output, 4 -- bit index within the frame: 0 = start, 1..8 = data, then parity, then stop.
REQ-016: Port data_valid, output, 1 -- one-cycle pulse; frame accepted.
REQ-017: Port frame_err, output, 1 -- one-cycle pulse on parity or stop error.

Function
REQ-018: States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019: In IDLE with RX_IN = 0, the block SHALL transition to START, and the next cycle SHALL show edge_cnt = 0 and bit_cnt = 0.
REQ-020: On leaving IDLE, Prescale and PAR_EN SHALL be latched; input changes mid-frame SHALL be ignored.
REQ-021: A latched Prescale other than 16 or 32 SHALL be treated as P = 8.
REQ-022: Outside IDLE, edge_cnt SHALL increment each cycle and wrap from P-1 to 0; at the wrap, bit_cnt SHALL increment.
REQ-023: In IDLE, edge_cnt and bit_cnt SHALL be held at 0.
REQ-024: dat_samp_en SHALL be 1 in every state except IDLE.
REQ-025: The check strobe for the current state SHALL assert for exactly one cycle at edge_cnt = P/2+2: strt_chk_en in START, deser_en in DATA, par_chk_en in PARITY, stp_chk_en in STOP.
REQ-026: START, at edge_cnt = P-1: if strt_glitch = 1, go to IDLE with no pulse; otherwise go to DATA.
REQ-027: DATA, at edge_cnt = P-1 with bit_cnt = 8: go to PARITY if latched PAR_EN = 1, else to STOP.
REQ-028: PARITY, at edge_cnt = P-1: go to STOP.
REQ-029: STOP, at edge_cnt = P-1: go to IDLE.
REQ-030: On the STOP exit cycle, if par_err = 0 (or parity is disabled) and stp_err = 0, data_valid SHALL pulse for the following cycle; otherwise frame_err SHALL pulse for that cycle.
REQ-031: data_valid and frame_err SHALL never be asserted together.
REQ-032: A low RX_IN on the cycle the block enters IDLE SHALL be evaluated on the next cycle; no bit is skipped beyond that one cycle.

Reset
REQ-033: While RST = 1 at a clock edge, state SHALL become IDLE, all counters 0, and all outputs 0, including mid-frame.
REQ-034: No data_valid or frame_err SHALL be issued for a frame interrupted by reset.

Structure
REQ-035: The state enum and the legal prescale constants (8, 16, 32) SHALL reside in the shared uart_rx_pkg package.
REQ-036: The edge/bit counters SHALL be implemented as sub-module edge_bit_counter, with enable = state != IDLE and wrap limit = P-1.

Verification
REQ-037: P = 8, PAR_EN = 0, frame 0x55 with a good stop bit -> strt_chk_en at edge 6 of bit 0, eight deser_en strobes, data_valid for one cycle 80 cycles after the start edge.
REQ-038: P = 16, PAR_EN = 1, stub par_err = 1 -> par_chk_en at edge 10 of bit 9, frame_err pulse, no data_valid.
REQ-039: RX_IN low for 3 cycles at P = 8 with stub strt_glitch = 1 -> return to IDLE after edge 7, no pulses, no deser_en.
REQ-040: P = 32, stub stp_err = 1 -> frame_err pulse at frame end, then IDLE.
REQ-041: RST asserted during DATA bit 4 -> next cycle IDLE with all outputs 0; a subsequent frame is received correctly.
REQ-042: Prescale changed from 8 to 16 mid-frame -> bit timing stays at 8 until IDLE; Prescale = 12 behaves as 8.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the frame state enum and the legal oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic [3:0] LAST_DATA_BIT = 4'd8;

    // Any ratio other than 16 or 32 falls back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        if (p == PRESCALE_16) begin
            return PRESCALE_16;
        end else if (p == PRESCALE_32) begin
            return PRESCALE_32;
        end else begin
            return PRESCALE_8;
        end
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample edge counter with a bit counter that advances on each wrap.
// Clearing has priority so the counters read zero whenever the FSM is idle.
module edge_bit_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [5:0] limit,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       wrap
);

    assign wrap = en && (edge_cnt == limit);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start, data, parity and stop
// bits and strobes the per-bit checkers at the mid-bit sample point.
import uart_rx_pkg::*;

module uart_rx_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       data_valid,
    output logic       frame_err
);

    rx_state_t  state;
    rx_state_t  next_state;
    logic [5:0] p_lat;
    logic       par_en_lat;
    logic [5:0] limit;
    logic [5:0] mid_edge;
    logic       mid;
    logic       wrap;
    logic       cnt_en;
    logic       cnt_clr;
    logic       dv_next;
    logic       fe_next;

    assign limit    = p_lat - 6'd1;
    assign mid_edge = {1'b0, p_lat[5:1]} + 6'd2;
    assign mid      = (edge_cnt == mid_edge);
    assign cnt_en   = (state != IDLE);
    assign cnt_clr  = (next_state == IDLE);

    edge_bit_counter u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .limit    (limit),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .wrap     (wrap)
    );

    // Frame parameters are frozen at the start edge for the whole frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            p_lat      <= PRESCALE_8;
            par_en_lat <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= next_state;
            data_valid <= dv_next;
            frame_err  <= fe_next;
            if (state == IDLE && !RX_IN) begin
                p_lat      <= legal_prescale(Prescale);
                par_en_lat <= PAR_EN;
            end
        end
    end

    always_comb begin
        next_state  = state;
        dat_samp_en = (state != IDLE);
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        dv_next     = 1'b0;
        fe_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN) next_state = START;
            end
            START: begin
                strt_chk_en = mid;
                if (wrap) next_state = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                deser_en = mid;
                if (wrap && bit_cnt == LAST_DATA_BIT)
                    next_state = par_en_lat ? PARITY : STOP;
            end
            PARITY: begin
                par_chk_en = mid;
                if (wrap) next_state = STOP;
            end
            STOP: begin
                stp_chk_en = mid;
                if (wrap) begin
                    next_state = IDLE;
                    if ((par_en_lat && par_err) || stp_err) fe_next = 1'b1;
                    else dv_next = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
